// File: rtl/spi_ram_burst.sv
// Word-addressed RAM behind the SPI slave frame decoder.
// Separate write/read pointers, multi-frame address load, burst increment.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        OP_WADDR = 2'b00,
        OP_WDATA = 2'b01,
        OP_RADDR = 2'b10,
        OP_RDATA = 2'b11
    } op_t;

    op_t                      op;
    logic [DATA_W-1:0]        payload;
    logic [ADDR_W-1:0]        wptr;
    logic [ADDR_W-1:0]        rptr;
    logic [ADDR_W+DATA_W-1:0] wshift;
    logic [ADDR_W+DATA_W-1:0] rshift;
    logic                     w_ok;
    logic                     r_ok;
    logic [IDX_W-1:0]         widx;
    logic [IDX_W-1:0]         ridx;
    logic [DATA_W-1:0]        mem [MEM_DEPTH];

    assign op      = op_t'(din[DATA_W+1:DATA_W]);
    assign payload = din[DATA_W-1:0];
    // MSB-first shift-in: older frames move up, the low ADDR_W bits survive
    assign wshift  = {wptr, payload};
    assign rshift  = {rptr, payload};
    assign w_ok    = {1'b0, wptr} < DEPTH;
    assign r_ok    = {1'b0, rptr} < DEPTH;
    assign widx    = wptr[IDX_W-1:0];
    assign ridx    = rptr[IDX_W-1:0];

    function automatic logic [ADDR_W-1:0] advance(
        input logic [ADDR_W-1:0] p,
        input logic              ok
    );
        if (!ok)
            return '0;
        if (AUTO_INC == 0)
            return p;
        return (p == LAST) ? '0 : p + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && op == OP_WDATA && w_ok)
            mem[widx] <= payload;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            if (rx_valid) begin
                unique case (op)
                    OP_WADDR: wptr <= wshift[ADDR_W-1:0];
                    OP_WDATA: begin
                        wptr <= advance(wptr, w_ok);
                        err  <= !w_ok;
                    end
                    OP_RADDR: rptr <= rshift[ADDR_W-1:0];
                    OP_RDATA: begin
                        tx_valid <= 1'b1;
                        err      <= !r_ok;
                        rptr     <= advance(rptr, r_ok);
                        dout     <= r_ok ? mem[ridx] : '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three configurations share one frame stream,
// each tracked by a word-level model of pointers and memory.
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout0, dout1, dout2;
    logic [2:0] txv, erv;

    always #5 clk = ~clk;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout0), .tx_valid(txv[0]), .err(erv[0]));

    spi_ram_burst #(.DATA_W(8), .ADDR_W(10), .MEM_DEPTH(600), .AUTO_INC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout1), .tx_valid(txv[1]), .err(erv[1]));

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout2), .tx_valid(txv[2]), .err(erv[2]));

    localparam logic [1:0] WA = 2'b00;
    localparam logic [1:0] WD = 2'b01;
    localparam logic [1:0] RA = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    int aw[3]   = '{8, 10, 8};
    int dep[3]  = '{256, 600, 256};
    int ainc[3] = '{1, 1, 0};

    int wp[3];
    int rp[3];
    int mem[3][1024];
    bit mk[3][1024];
    bit ex_tx[3];
    bit ex_err[3];
    bit dk[3];
    int ex_dout[3];

    int nvec = 0;
    int nbad = 0;
    bit armed = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] dv(int k);
        case (k)
            0: return dout0;
            1: return dout1;
            default: return dout2;
        endcase
    endfunction

    function automatic int adv(int k, int p);
        return (ainc[k] != 0) ? (p + 1) % dep[k] : p;
    endfunction

    function automatic void step(int k, logic r, logic v, logic [9:0] d);
        int op = int'(d[9:8]);
        int pl = int'(d[7:0]);
        if (!r) begin
            wp[k] = 0; rp[k] = 0;
            ex_tx[k] = 0; ex_err[k] = 0;
            ex_dout[k] = 0; dk[k] = 1;
            return;
        end
        ex_tx[k] = 0;
        ex_err[k] = 0;
        if (!v)
            return;
        case (op)
            0: wp[k] = ((wp[k] << 8) | pl) % (1 << aw[k]);
            1: begin
                if (wp[k] < dep[k]) begin
                    mem[k][wp[k]] = pl;
                    mk[k][wp[k]] = 1;
                    wp[k] = adv(k, wp[k]);
                end else begin
                    ex_err[k] = 1;
                    wp[k] = 0;
                end
            end
            2: rp[k] = ((rp[k] << 8) | pl) % (1 << aw[k]);
            default: begin
                ex_tx[k] = 1;
                if (rp[k] < dep[k]) begin
                    ex_dout[k] = mem[k][rp[k]];
                    dk[k] = mk[k][rp[k]];
                    rp[k] = adv(k, rp[k]);
                end else begin
                    ex_dout[k] = 0;
                    dk[k] = 1;
                    ex_err[k] = 1;
                    rp[k] = 0;
                end
            end
        endcase
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [9:0] d);
        rst_n = r;
        rx_valid = v;
        din = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++)
            step(k, r, v, d);
        if (!r)
            armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic fr(input logic [1:0] op, input logic [7:0] pl);
        cyc(1'b1, 1'b1, {op, pl});
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tx_valid[%0d]", k), txv[k], ex_tx[k]);
                chk($sformatf("err[%0d]", k), erv[k], ex_err[k]);
                if (dk[k])
                    chk($sformatf("dout[%0d]", k), dv(k), ex_dout[k]);
            end
        end
    end

    initial begin
        cyc(1'b0, 1'b0, 10'h0);
        cyc(1'b0, 1'b1, {RD, 8'h00});
        chk("reset_tx", txv[0], 0);
        chk("reset_dout", dout0, 0);
        chk("reset_err", erv[0], 0);

        fr(WA, 8'h10); fr(WD, 8'hA5); fr(RA, 8'h10); fr(RD, 8'h00);
        chk("basic_tx", txv[0], 1);
        chk("basic_dout", dout0, 8'hA5);
        chk("basic_err", erv[0], 0);
        cyc(1'b1, 1'b0, 10'h0);
        chk("basic_tx_one", txv[0], 0);
        chk("basic_hold", dout0, 8'hA5);

        fr(WA, 8'hFE); fr(WD, 8'h11); fr(WD, 8'h22); fr(WD, 8'h33);
        fr(RA, 8'hFE);
        fr(RD, 8'h00); chk("burst0", dout0, 8'h11); chk("burst0_tx", txv[0], 1);
        fr(RD, 8'h00); chk("burst1", dout0, 8'h22); chk("burst1_tx", txv[0], 1);
        fr(RD, 8'h00); chk("burst_wrap", dout0, 8'h33); chk("burst2_tx", txv[0], 1);
        cyc(1'b1, 1'b0, 10'h0);
        chk("burst_end_tx", txv[0], 0);

        fr(WA, 8'h02); fr(WA, 8'h58); fr(WD, 8'h7E);
        chk("oor_err", erv[1], 1);
        chk("inrange_noerr", erv[0], 0);
        fr(WD, 8'h7F);
        chk("oor_clear", erv[1], 0);
        fr(RA, 8'h00); fr(RA, 8'h00); fr(RD, 8'h00);
        chk("oor_wrote0", dout1, 8'h7F);
        fr(RA, 8'h02); fr(RA, 8'h58); fr(RD, 8'h00);
        chk("oor_rd_err", erv[1], 1);
        chk("oor_rd_tx", txv[1], 1);
        chk("oor_rd_dout", dout1, 0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, {RD, 8'($urandom)});
            chk("idle_tx", txv[0], 0);
        end

        fr(WA, 8'h20); fr(WD, 8'h3C); fr(RA, 8'h20);
        fr(RD, 8'h00); chk("noinc0", dout2, 8'h3C);
        fr(RD, 8'h00); chk("noinc1", dout2, 8'h3C);

        fr(WA, 8'h40); fr(WD, 8'h44); fr(WD, 8'h45);
        fr(WA, 8'h05); fr(RA, 8'h40); fr(WD, 8'h99);
        fr(RD, 8'h00); chk("indep_rd", dout0, 8'h44);
        fr(RD, 8'h00); chk("indep_rptr41", dout0, 8'h45);
        fr(WD, 8'h66);
        fr(RA, 8'h05); fr(RD, 8'h00); chk("indep_wr", dout0, 8'h99);
        fr(RD, 8'h00); chk("indep_wptr06", dout0, 8'h66);

        fr(RA, 8'h10); fr(RD, 8'h00);
        cyc(1'b0, 1'b1, {RD, 8'h00});
        chk("midrst_tx", txv[0], 0);
        chk("midrst_dout", dout0, 0);
        chk("midrst_err", erv[0], 0);
        fr(RD, 8'h00); chk("midrst_rptr0", dout0, 8'h33);
        fr(RA, 8'h10); fr(RD, 8'h00); chk("mem_kept", dout0, 8'hA5);

        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, 10'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
